// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, DIFF = A - B,
// processed LSB first, one full-subtractor cell per clock with a borrow
// flip-flop carrying the borrow between bits. Controlled by start/busy/done.
// Optional build macro: SERSUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Counter holds 0..WIDTH-1 with headroom so it can never wrap.
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // One full-subtractor cell: returns {borrow_out, difference_bit}.
   function automatic logic [1:0] fs_cell(input logic ai, input logic bi, input logic bri);
      logic d;
      logic bo;
      d  = ai ^ bi ^ bri;
      bo = (~ai & bi) | (~(ai ^ bi) & bri);
      fs_cell = {bo, d};
   endfunction

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] res_r;
   logic [CW-1:0]    cnt_r;
   logic             br_r;
   logic [WIDTH-1:0] diff_r;
   logic             bout_r;
   logic             busy_r;
   logic             done_r;
   logic [1:0]       cell_s;
   logic             d_s;
   logic             br_nxt_s;
   logic             last_s;
   logic             accept_s;
`ifdef SERSUB_OVF_EN
   logic             ovf_r;
`endif

   // Current-bit subtract, last-bit detect and start acceptance.
   always_comb begin
      cell_s   = fs_cell(a_sh_r[0], b_sh_r[0], br_r);
      d_s      = cell_s[0];
      br_nxt_s = cell_s[1];
      last_s   = (cnt_r == CW'(WIDTH - 1));
      accept_s = start && (state_r != SHIFT);
   end

   // Next-state logic: IDLE/DONE accept start, SHIFT runs WIDTH bits, DONE lasts one cycle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE: begin
            if (start) begin
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register plus registered busy/done decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == SHIFT);
         done_r  <= (state_s == DONE);
      end
   end

   // Datapath: load operands on accept, shift one bit per SHIFT cycle,
   // publish diff/bout (and ovf) only on the final bit so partial results stay hidden.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_r <= {WIDTH{1'b0}};
         b_sh_r <= {WIDTH{1'b0}};
         res_r  <= {WIDTH{1'b0}};
         cnt_r  <= {CW{1'b0}};
         br_r   <= 1'b0;
         diff_r <= {WIDTH{1'b0}};
         bout_r <= 1'b0;
`ifdef SERSUB_OVF_EN
         ovf_r  <= 1'b0;
`endif
      end else if (accept_s) begin
         a_sh_r <= a;
         b_sh_r <= b;
         cnt_r  <= {CW{1'b0}};
         br_r   <= 1'b0;
      end else if (state_r == SHIFT) begin
         a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
         b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
         res_r  <= {d_s, res_r[WIDTH-1:1]};
         br_r   <= br_nxt_s;
         cnt_r  <= cnt_r + CW'(1);
         if (last_s) begin
            diff_r <= {d_s, res_r[WIDTH-1:1]};
            bout_r <= br_nxt_s;
`ifdef SERSUB_OVF_EN
            // On the last bit the shift registers' LSBs are the captured sign bits.
            ovf_r  <= (a_sh_r[0] != b_sh_r[0]) && (d_s != a_sh_r[0]);
`endif
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign diff = diff_r;
   assign bout = bout_r;
`ifdef SERSUB_OVF_EN
   assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed corner cases,
// held-start/changing-operand runs, back-to-back operations, async reset and
// randomized operations against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
`ifdef SERSUB_OVF_EN
   logic         ovf;
`endif

   int n_cmp;
   int n_err;
   logic [W-1:0] prev_diff;
   logic         prev_bout;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERSUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [W-1:0] ref_diff(input logic [W-1:0] av, input logic [W-1:0] bv);
      int d;
      d = int'(av) - int'(bv);
      return W'(d & 255);
   endfunction

   function automatic logic ref_bout(input logic [W-1:0] av, input logic [W-1:0] bv);
      return int'(av) < int'(bv);
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv);
      int sa;
      int sb;
      int sd;
      sa = (int'(av) >= 128) ? int'(av) - 256 : int'(av);
      sb = (int'(bv) >= 128) ? int'(bv) - 256 : int'(bv);
      sd = sa - sb;
      return (sd > 127) || (sd < -128);
   endfunction

   // Runs one operation. Entered just after a negedge; if pre=1 the start and
   // operands were already driven at the previous done. Returns at the done
   // negedge, having driven start/operands for a chained op when chain=1.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold,
                         input bit pre, input bit chain, input logic [W-1:0] nav, input logic [W-1:0] nbv);
      int lat;
      if (!pre) begin
         a = av;
         b = bv;
         start = 1'b1;
      end
      @(negedge clk);
      lat = 1;
      if (!hold) start = 1'b0;
      while (!done && lat < 30) begin
         check_val("busy_in_flight", 32'(busy), 32'd1);
         check_val("diff_hidden", 32'(diff), 32'(prev_diff));
         if (hold) begin
            a = W'($urandom);
            b = W'($urandom);
            start = 1'b1;
         end
         @(negedge clk);
         lat++;
      end
      check_val("latency", 32'(lat), 32'd9);
      check_val("done", 32'(done), 32'd1);
      check_val("busy_at_done", 32'(busy), 32'd0);
      check_val("diff", 32'(diff), 32'(ref_diff(av, bv)));
      check_val("bout", 32'(bout), 32'(ref_bout(av, bv)));
`ifdef SERSUB_OVF_EN
      check_val("ovf", 32'(ovf), 32'(ref_ovf(av, bv)));
`endif
      prev_diff = ref_diff(av, bv);
      prev_bout = ref_bout(av, bv);
      if (chain) begin
         a = nav;
         b = nbv;
         start = 1'b1;
      end else begin
         start = 1'b0;
      end
   endtask

   // After a non-chained op: done must drop and the result must hold.
   task automatic check_idle();
      @(negedge clk);
      check_val("done_one_cycle", 32'(done), 32'd0);
      check_val("busy_idle", 32'(busy), 32'd0);
      check_val("diff_held", 32'(diff), 32'(prev_diff));
      check_val("bout_held", 32'(bout), 32'(prev_bout));
   endtask

   initial begin
      logic [W-1:0] da [6];
      logic [W-1:0] db [6];
      logic [W-1:0] ca;
      logic [W-1:0] cb;
      logic [W-1:0] na;
      logic [W-1:0] nb;
      bit           pre;
      bit           chain;
      bit           hold;

      n_cmp = 0;
      n_err = 0;
      prev_diff = '0;
      prev_bout = 1'b0;
      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_diff", 32'(diff), 32'd0);
      check_val("rst_bout", 32'(bout), 32'd0);
`ifdef SERSUB_OVF_EN
      check_val("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases: basic, underflow, signed overflow both ways, extremes.
      da = '{8'h05, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'hA5};
      db = '{8'h03, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'h5A};
      for (int i = 0; i < 6; i++) begin
         run_op(da[i], db[i], 1'b0, 1'b0, 1'b0, '0, '0);
         check_idle();
      end

      // Start held high with operands changing while busy.
      for (int i = 0; i < 4; i++) begin
         run_op(W'($urandom), W'($urandom), 1'b1, 1'b0, 1'b0, '0, '0);
         check_idle();
      end

      // Back-to-back chain of three operations.
      run_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'h33, 8'h11);
      run_op(8'h33, 8'h11, 1'b0, 1'b1, 1'b1, 8'h01, 8'h80);
      run_op(8'h01, 8'h80, 1'b0, 1'b1, 1'b0, '0, '0);
      check_idle();

      // Randomized operations with random holds and chaining.
      ca = W'($urandom);
      cb = W'($urandom);
      pre = 1'b0;
      for (int i = 0; i < 300; i++) begin
         na = W'($urandom);
         nb = W'($urandom);
         hold = ($urandom_range(0, 3) == 0);
         chain = (i < 299) && ($urandom_range(0, 2) == 0);
         run_op(ca, cb, hold, pre, chain, na, nb);
         if (!chain) check_idle();
         ca = na;
         cb = nb;
         pre = chain;
      end

      // Async reset mid-SHIFT: outputs clear immediately, before any edge.
      run_op(8'hC3, 8'h21, 1'b0, 1'b0, 1'b0, '0, '0);
      check_idle();
      a = 8'h44;
      b = 8'h01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_busy", 32'(busy), 32'd0);
      check_val("arst_done", 32'(done), 32'd0);
      check_val("arst_diff", 32'(diff), 32'd0);
      check_val("arst_bout", 32'(bout), 32'd0);
`ifdef SERSUB_OVF_EN
      check_val("arst_ovf", 32'(ovf), 32'd0);
`endif
      prev_diff = '0;
      prev_bout = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("post_rst_busy", 32'(busy), 32'd0);
      run_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0, '0, '0);
      check_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
